decompress_length_parser: RTL and testbench
===========================================

Name: decompress_length_parser

Overview:
- Decompression-side counterpart of the compressor's length-generation and packing path.
- Accepts the packed compressed bitstream in WORD_SIZE-bit chunks and keeps a bit buffer.
- Per cycle, decodes up to two 32-bit word codes (prefix, dictionary index, literal) and removes exactly their code lengths from the buffer.
- At the end of each cache line, discards the padding up to the next WORD_SIZE boundary and feeds the dictionary/reconstruction stage downstream.

Parameters:
- CACHE_LINE, 128, bits per uncompressed line; words per line = CACHE_LINE/32 = 4, i.e. two decode pairs.
- WORD_SIZE, 64, width of an input chunk and the line-padding granularity.
- BUF_WIDTH, 192, bit-buffer capacity; must be at least 2*34 + WORD_SIZE.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  asynchronous, active-low reset.
- i_chunk  in  WORD_SIZE  packed stream chunk, MSB first.
- i_chunk_valid  in  1  chunk present.
- o_chunk_ready  out  1  chunk accepted when valid&&ready.
- o_valid  out  1  decoded pair valid.
- i_ready  in  1  downstream accepts the pair.
- o_code1 / o_code2  out  3 each  word code: 000 zzzz, 001 xxxx, 010 mmmm, 011 mmxx, 100 zzzx, 101 mmmx.
- o_idx1 / o_idx2  out  4 each  dictionary index; 0 when the code has none.
- o_lit1 / o_lit2  out  32 each  literal, right-justified and zero-extended.
- o_len1 / o_len2  out  6 each  code length in bits.
- o_line_done  out  1  one-cycle pulse when a line's padding is discarded.
- o_error  out  1  sticky illegal-prefix flag.

Behaviour:
- Reset (i_reset=0, async): buffer count=0; state=DECODE; pair count=0; line bit count=0; all outputs 0. o_chunk_ready is also 0 while reset is asserted.
- Code table, MSB-first, head of buffer = MSB:
  - 00 → zzzz, len 2.
  - 01 + 32 literal bits → xxxx, len 34.
  - 10 + idx4 → mmmm, len 6.
  - 1100 + idx4 + 16 literal bits → mmxx, len 24.
  - 1101 + 8 literal bits → zzzx, len 12.
  - 1110 + idx4 + 8 literal bits → mmmx, len 16.
  - 1111 → illegal.
- Buffer:
  - o_chunk_ready = (count <= BUF_WIDTH-WORD_SIZE) && !o_error && state==DECODE.
  - An accepted chunk is placed immediately after the last valid bit.
  - Same-cycle update: count_next = count + WORD_SIZE*accept - consumed.
- Decode (state DECODE):
  - Word1 is decoded combinationally from buffer[head]; word2 is decoded at offset len1.
  - A pair fires when count >= len1+len2 AND (!o_valid || i_ready) AND !o_error.
  - On fire: output registers load next cycle (latency 1); o_valid=1; buffer shifts left by len1+len2; line bit count += len1+len2; pair count += 1.
  - If the length check uses a partially valid word2 prefix, no fire occurs; wait for more bits.
- Handshake: o_valid and all outputs are held stable until i_ready. A new pair may load in the same cycle the old one is accepted (full throughput).
- Line end: after firing pair CACHE_LINE/64, go to ALIGN.
- ALIGN (1 cycle):
  - pad = (WORD_SIZE - linebits % WORD_SIZE) % WORD_SIZE; drop pad bits.
  - Pulse o_line_done; clear line bit count and pair count; return to DECODE.
  - No chunk is accepted in ALIGN.
  - count >= pad is guaranteed; if violated, set o_error.
- Maximum line length is 4*34 = 136 bits; the line bit counter is 8 bits wide.
- Illegal prefix 1111 in either word of a pair that would otherwise fire:
  - Set o_error and stop all decoding and chunk acceptance until reset.
  - The pending o_valid still completes its handshake.
- Downstream stall with a full buffer: o_chunk_ready drops; no bits are lost or duplicated.
- Reset mid-line: all partial state is discarded and the next accepted chunk is treated as a line start.

Test Plan:
- All-zero line:
  - Stimulus: chunk 64'h0.
  - Required: two pairs, each code 000/000, len 2/2.
  - ALIGN drops 56 bits; o_line_done pulses once; count returns to 0.
- Uncompressed line:
  - Stimulus: 4 literals 32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'hCAFEF00D = 136 bits plus 56 pad = 3 chunks.
  - Required: pairs (001,001) with literals in order, len 34.
  - o_line_done after the second pair; no extra bits remain.
- Mixed line:
  - Stimulus: mmmm idx 3, mmxx idx 5 lit 16'hBEEF, zzzx lit 8'h7F, mmmx idx 9 lit 8'hA5 (58 bits, pad 6).
  - Required: exact codes, indices, literals and lengths as given.
  - The next line's first word decodes correctly from the following chunk.
- Backpressure:
  - Stimulus: i_ready=0 for 10 cycles while chunks are offered.
  - Required: o_valid held with stable fields; o_chunk_ready goes low once count > 128; after release, all pairs arrive in order with no loss.
- Illegal prefix:
  - Stimulus: chunk starting with 4'b1111.
  - Required: o_error=1 and stays 1; o_valid never asserts; o_chunk_ready=0 until reset.
- Reset mid-line:
  - Stimulus: assert i_reset after the first pair, then feed a fresh all-zero line.
  - Required: outputs cleared asynchronously; the new line decodes as in the all-zero test.

Source files
------------

// File: rtl/decompress_length_parser_if.sv
// Stream-side and decoded-pair-side signals of the length parser, grouped so
// the parser and its neighbours connect through one bundle.
interface decompress_length_parser_if #(
  parameter int WORD_SIZE = 64
);
  logic [WORD_SIZE-1:0] i_chunk;
  logic                 i_chunk_valid;
  logic                 o_chunk_ready;
  logic                 o_valid;
  logic                 i_ready;
  logic [2:0]           o_code1, o_code2;
  logic [3:0]           o_idx1, o_idx2;
  logic [31:0]          o_lit1, o_lit2;
  logic [5:0]           o_len1, o_len2;
  logic                 o_line_done;
  logic                 o_error;

  modport slave (
    input  i_chunk, i_chunk_valid, i_ready,
    output o_chunk_ready, o_valid, o_code1, o_code2, o_idx1, o_idx2,
           o_lit1, o_lit2, o_len1, o_len2, o_line_done, o_error
  );

  modport master (
    output i_chunk, i_chunk_valid, i_ready,
    input  o_chunk_ready, o_valid, o_code1, o_code2, o_idx1, o_idx2,
           o_lit1, o_lit2, o_len1, o_len2, o_line_done, o_error
  );
endinterface

// File: rtl/decompress_length_parser.sv
// Bit-buffered parser for the packed compressed stream: decodes two word codes
// per cycle, and drops the per-line padding up to the next chunk boundary.
module decompress_length_parser #(
  parameter int CACHE_LINE = 128,
  parameter int WORD_SIZE  = 64,
  parameter int BUF_WIDTH  = 192
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  decompress_length_parser_if.slave   bus
);

  localparam int CW    = $clog2(BUF_WIDTH + 1);
  localparam int BW    = $clog2(BUF_WIDTH);
  localparam int PAIRS = CACHE_LINE / 64;
  localparam int PW    = (PAIRS > 1) ? $clog2(PAIRS) : 1;

  typedef enum logic [0:0] {S_DECODE, S_ALIGN} state_t;

  typedef struct packed {
    logic [2:0]  code;
    logic [3:0]  idx;
    logic [31:0] lit;
    logic [5:0]  len;
  } out_t;

  typedef struct packed {
    out_t f;
    logic ill;
  } word_t;

  // w[33] is the oldest bit in the stream; illegal codes report len 4 so the
  // prefix itself is the only thing the availability check depends on.
  function automatic word_t dec(input logic [33:0] w);
    word_t d;
    d = '0;
    case (w[33:32])
      2'b00: begin d.f.code = 3'b000; d.f.len = 6'd2; end
      2'b01: begin d.f.code = 3'b001; d.f.lit = w[31:0]; d.f.len = 6'd34; end
      2'b10: begin d.f.code = 3'b010; d.f.idx = w[31:28]; d.f.len = 6'd6; end
      default: begin
        case (w[31:30])
          2'b00: begin
            d.f.code = 3'b011; d.f.idx = w[29:26];
            d.f.lit  = {16'b0, w[25:10]}; d.f.len = 6'd24;
          end
          2'b01: begin
            d.f.code = 3'b100; d.f.lit = {24'b0, w[29:22]}; d.f.len = 6'd12;
          end
          2'b10: begin
            d.f.code = 3'b101; d.f.idx = w[29:26];
            d.f.lit  = {24'b0, w[25:18]}; d.f.len = 6'd16;
          end
          default: begin d.ill = 1'b1; d.f.len = 6'd4; end
        endcase
      end
    endcase
    return d;
  endfunction

  logic [BUF_WIDTH-1:0] buf_q, buf_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [7:0]           lbits_q, lbits_d;
  logic [PW-1:0]        pairs_q, pairs_d;
  state_t               state_q, state_d;
  logic                 err_q, err_d;
  logic                 vld_q, vld_d;
  out_t                 o1_q, o1_d, o2_q, o2_d;

  word_t                w1, w2;
  logic [BW-1:0]        pos2;
  logic [6:0]           need;
  logic [CW-1:0]        drop, rem, pad;
  logic                 chunk_ready, accept, fire, ill_hit;

  always_comb begin
    w1   = dec(buf_q[BUF_WIDTH-1 -: 34]);
    pos2 = BW'(BUF_WIDTH - 1) - BW'(w1.f.len);
    w2   = dec(buf_q[pos2 -: 34]);
    need = 7'(w1.f.len) + 7'(w2.f.len);
    pad  = CW'((WORD_SIZE - (int'(lbits_q) % WORD_SIZE)) % WORD_SIZE);

    chunk_ready = i_reset && !err_q && (state_q == S_DECODE) &&
                  (cnt_q <= CW'(BUF_WIDTH - WORD_SIZE));
    accept      = chunk_ready && bus.i_chunk_valid;

    // Bits past cnt_q are always zero, so a len computed from a partly
    // valid prefix always exceeds cnt_q and cannot fire early.
    ill_hit = (state_q == S_DECODE) && !err_q &&
              ((w1.ill && cnt_q >= CW'(4)) ||
               (!w1.ill && w2.ill && cnt_q >= CW'(need)));
    fire    = (state_q == S_DECODE) && !err_q && !w1.ill && !w2.ill &&
              (cnt_q >= CW'(need)) && (!vld_q || bus.i_ready);

    state_d = state_q;
    err_d   = err_q;
    vld_d   = vld_q && !bus.i_ready;
    o1_d    = o1_q;
    o2_d    = o2_q;
    lbits_d = lbits_q;
    pairs_d = pairs_q;
    drop    = '0;

    case (state_q)
      S_DECODE: begin
        if (ill_hit) begin
          err_d = 1'b1;
        end else if (fire) begin
          drop    = CW'(need);
          vld_d   = 1'b1;
          o1_d    = w1.f;
          o2_d    = w2.f;
          lbits_d = lbits_q + 8'(need);
          if (pairs_q == PW'(PAIRS - 1)) begin
            state_d = S_ALIGN;
            pairs_d = '0;
          end else begin
            pairs_d = pairs_q + 1'b1;
          end
        end
      end
      S_ALIGN: begin
        state_d = S_DECODE;
        lbits_d = '0;
        pairs_d = '0;
        if (cnt_q < pad) err_d = 1'b1;
        else             drop  = pad;
      end
      default: state_d = S_DECODE;
    endcase

    // New chunk lands directly behind the bits that survive this cycle.
    rem   = cnt_q - drop;
    buf_d = (buf_q << drop) |
            (accept ? ({bus.i_chunk, {(BUF_WIDTH-WORD_SIZE){1'b0}}} >> rem)
                    : {BUF_WIDTH{1'b0}});
    cnt_d = rem + (accept ? CW'(WORD_SIZE) : CW'(0));
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      buf_q   <= '0;
      cnt_q   <= '0;
      lbits_q <= '0;
      pairs_q <= '0;
      state_q <= S_DECODE;
      err_q   <= 1'b0;
      vld_q   <= 1'b0;
      o1_q    <= '0;
      o2_q    <= '0;
    end else begin
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      lbits_q <= lbits_d;
      pairs_q <= pairs_d;
      state_q <= state_d;
      err_q   <= err_d;
      vld_q   <= vld_d;
      o1_q    <= o1_d;
      o2_q    <= o2_d;
    end
  end

  assign bus.o_chunk_ready = chunk_ready;
  assign bus.o_valid       = vld_q;
  assign bus.o_code1       = o1_q.code;
  assign bus.o_idx1        = o1_q.idx;
  assign bus.o_lit1        = o1_q.lit;
  assign bus.o_len1        = o1_q.len;
  assign bus.o_code2       = o2_q.code;
  assign bus.o_idx2        = o2_q.idx;
  assign bus.o_lit2        = o2_q.lit;
  assign bus.o_len2        = o2_q.len;
  assign bus.o_line_done   = (state_q == S_ALIGN);
  assign bus.o_error       = err_q;

endmodule

// File: tb/tb_decompress_length_parser.sv
// Directed bench for the length parser: expected pairs are queued with the
// stimulus and a negedge monitor pops them on every accepted o_valid.
module tb_decompress_length_parser;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  decompress_length_parser_if #(.WORD_SIZE(64)) bus ();

  decompress_length_parser #(
    .CACHE_LINE(128), .WORD_SIZE(64), .BUF_WIDTH(192)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .bus     (bus.slave)
  );

  typedef struct packed {
    logic [2:0] c1; logic [3:0] x1; logic [31:0] l1; logic [5:0] n1;
    logic [2:0] c2; logic [3:0] x2; logic [31:0] l2; logic [5:0] n2;
  } pair_t;

  pair_t q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    n_lines = 0;

  function automatic pair_t mk(input logic [2:0] c1, input logic [3:0] x1,
                               input logic [31:0] l1, input logic [5:0] n1,
                               input logic [2:0] c2, input logic [3:0] x2,
                               input logic [31:0] l2, input logic [5:0] n2);
    return '{c1, x1, l1, n1, c2, x2, l2, n2};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Monitor: scoreboard pops, hold-stability under backpressure, line pulses.
  initial begin : monitor
    pair_t cur, held_v, e;
    logic  held;
    held = 1'b0;
    held_v = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held = 1'b0;
      end else begin
        cur = {bus.o_code1, bus.o_idx1, bus.o_lit1, bus.o_len1,
               bus.o_code2, bus.o_idx2, bus.o_lit2, bus.o_len2};
        if (bus.o_line_done) n_lines++;
        if (held) begin
          n_cmp++;
          if (!bus.o_valid || cur !== held_v) begin
            n_bad++;
            $display("FAIL hold_stable: got v=%b %h want v=1 %h", bus.o_valid, cur, held_v);
          end
        end
        held   = bus.o_valid && !bus.i_ready;
        held_v = cur;
        if (bus.o_valid && bus.i_ready) begin
          n_cmp++;
          if (q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_pair: got %h want none", cur);
          end else begin
            e = q.pop_front();
            if (cur !== e) begin
              n_bad++;
              $display("FAIL pair: got %h want %h", cur, e);
            end
          end
        end
      end
    end
  end

  task automatic send(input logic [63:0] d);
    int t;
    bus.i_chunk       = d;
    bus.i_chunk_valid = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!bus.o_chunk_ready && t < 200);
    if (!bus.o_chunk_ready) chk("send_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    bus.i_chunk_valid = 1'b0;
  endtask

  task automatic wait_lines(input int n);
    int t;
    t = 0;
    while ((n_lines < n || q.size() != 0) && t < 400) begin
      @(posedge clk); #1;
      t++;
    end
    chk("lines_done", 64'(n_lines), 64'(n));
    chk("queue_drained", 64'(q.size()), 64'd0);
  endtask

  localparam logic [191:0] UNC = {2'b01, 32'hDEADBEEF, 2'b01, 32'h01234567,
                                  2'b01, 32'h89ABCDEF, 2'b01, 32'hCAFEF00D, 56'h0};
  localparam logic [63:0]  MIX = {2'b10, 4'd3, 4'b1100, 4'd5, 16'hBEEF,
                                  4'b1101, 8'h7F, 4'b1110, 4'd9, 8'hA5, 6'b0};
  localparam logic [63:0]  NXT = {2'b01, 32'h12345678, 2'b00, 2'b10, 4'hF,
                                  4'b1101, 8'h01, 10'b0};

  pair_t zp, u1, u2;
  logic [191:0] unc;

  initial begin
    unc = UNC;
    zp = mk(3'b000, 4'd0, 32'd0, 6'd2, 3'b000, 4'd0, 32'd0, 6'd2);
    u1 = mk(3'b001, 4'd0, 32'hDEADBEEF, 6'd34, 3'b001, 4'd0, 32'h01234567, 6'd34);
    u2 = mk(3'b001, 4'd0, 32'h89ABCDEF, 6'd34, 3'b001, 4'd0, 32'hCAFEF00D, 6'd34);

    rst_n = 1'b0;
    bus.i_chunk = '0;
    bus.i_chunk_valid = 1'b0;
    bus.i_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", 64'(bus.o_valid), 64'd0);
    chk("reset_ready", 64'(bus.o_chunk_ready), 64'd0);
    chk("reset_error", 64'(bus.o_error), 64'd0);
    chk("reset_linedone", 64'(bus.o_line_done), 64'd0);
    chk("reset_fields", {bus.o_code1, bus.o_idx1, bus.o_len1, bus.o_code2,
                         bus.o_idx2, bus.o_len2, bus.o_lit1 | bus.o_lit2}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // all-zero line
    q.push_back(zp); q.push_back(zp);
    send(64'h0);
    wait_lines(1);
    chk("zero_cnt", 64'(dut.cnt_q), 64'd0);

    // uncompressed line, three chunks
    q.push_back(u1); q.push_back(u2);
    send(unc[191:128]); send(unc[127:64]); send(unc[63:0]);
    wait_lines(2);
    chk("unc_cnt", 64'(dut.cnt_q), 64'd0);

    // mixed line followed by another line in the next chunk
    q.push_back(mk(3'b010, 4'd3, 32'h0, 6'd6, 3'b011, 4'd5, 32'h0000BEEF, 6'd24));
    q.push_back(mk(3'b100, 4'd0, 32'h7F, 6'd12, 3'b101, 4'd9, 32'hA5, 6'd16));
    q.push_back(mk(3'b001, 4'd0, 32'h12345678, 6'd34, 3'b000, 4'd0, 32'h0, 6'd2));
    q.push_back(mk(3'b010, 4'hF, 32'h0, 6'd6, 3'b100, 4'd0, 32'h01, 6'd12));
    send(MIX); send(NXT);
    wait_lines(4);
    chk("mix_cnt", 64'(dut.cnt_q), 64'd0);

    // backpressure: buffer fills while the first pair is held
    bus.i_ready = 1'b0;
    q.push_back(u1); q.push_back(u2); q.push_back(zp); q.push_back(zp);
    send(unc[191:128]); send(unc[127:64]); send(unc[63:0]); send(64'h0);
    repeat (6) @(negedge clk);
    chk("bp_ready_low", 64'(bus.o_chunk_ready), 64'd0);
    chk("bp_valid_held", 64'(bus.o_valid), 64'd1);
    chk("bp_cnt", 64'(dut.cnt_q), 64'd188);
    @(posedge clk); #1;
    bus.i_ready = 1'b1;
    wait_lines(6);

    // reset after the first pair of a line
    q.push_back(u1);
    send(unc[191:128]); send(unc[127:64]);
    for (int t = 0; t < 50 && q.size() != 0; t++) begin
      @(posedge clk); #1;
    end
    chk("midline_pair_seen", 64'(q.size()), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 64'(bus.o_valid), 64'd0);
    chk("midrst_ready", 64'(bus.o_chunk_ready), 64'd0);
    chk("midrst_cnt", 64'(dut.cnt_q), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    q.push_back(zp); q.push_back(zp);
    send(64'h0);
    wait_lines(7);

    // illegal prefix: error is sticky, nothing decodes, nothing accepted
    send(64'hF000_0000_0000_0000);
    @(posedge clk); #1;
    bus.i_chunk = 64'h0;
    bus.i_chunk_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("ill_error", 64'(bus.o_error), 64'd1);
      chk("ill_ready", 64'(bus.o_chunk_ready), 64'd0);
      chk("ill_valid", 64'(bus.o_valid), 64'd0);
    end
    chk("ill_cnt", 64'(dut.cnt_q), 64'd64);
    @(posedge clk); #1;
    bus.i_chunk_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("ill_rst_error", 64'(bus.o_error), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 64'(bus.o_chunk_ready), 64'd1);
    chk("final_queue", 64'(q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
